mem_access_arbiter: RTL and testbench
=====================================

// Module: mem_access_arbiter
// PURPOSE
//  Sits between the core's fetch and load/store stages and the byte-lane memory/MMIO block.
//  Arbitrates the single memory port between instruction fetch (IF) and data (D) requests.
//  Checks alignment and address range, and drives memory address, data, funct3 and write strobe.
//  Routes the 1-cycle-latency read data back to the requester that issued the access.
// PARAMETERS
//  STARVE_LIMIT   4    consecutive data wins while IF waits before IF is forced (0 = IF always wins)
//  RAM_ADDR_BITS  13   RAM occupies [0, 2**RAM_ADDR_BITS); MMIO is the top 3 words 0xFFFFFFF4..0xFFFFFFFC
// PORTS
//  clk               in   1   clock
//  rst               in   1   async active-high reset
//  if_req            in   1   fetch request, held until if_ready
//  if_addr           in   32  fetch address
//  if_ready          out  1   fetch accepted this cycle
//  if_rvalid         out  1   fetch response valid, one cycle after acceptance
//  if_rdata          out  32  fetched word
//  if_err            out  1   with if_rvalid: misaligned or out-of-range fetch
//  d_req             in   1   data request, held until d_ready
//  d_we              in   1   1 = store, 0 = load
//  d_funct3          in   3   RISC-V load/store funct3
//  d_addr            in   32  data address
//  d_wdata           in   32  store data (low bytes used for SB/SH)
//  d_ready           out  1   data request accepted this cycle
//  d_rvalid          out  1   data response, one cycle after acceptance (loads and stores)
//  d_rdata           out  32  load result already extended by memory; 0 for stores/errors
//  d_err             out  1   with d_rvalid: misaligned or out-of-range access
//  mem_write         out  1   memory write strobe
//  mem_funct3        out  3   memory access size/sign
//  mem_write_address out  32  memory write address
//  mem_write_data    out  32  memory write data
//  mem_read_address  out  32  memory read address
//  mem_read_data     in   32  memory read data, valid one cycle after read address
// BEHAVIOUR
//  - At most one request is granted per cycle. The memory funct3 is shared by the read and write paths, so no concurrent fetch+store.
//  - Grant rule (combinational):
//    - fetch_force = if_req & (starve_cnt == STARVE_LIMIT).
//    - d_ready = d_req & ~fetch_force.
//    - if_ready = if_req & ~d_ready.
//  - starve_cnt (sequential):
//    - Cleared when if_ready=1 or if_req=0.
//    - Otherwise increments when d_ready=1 & if_req=1, saturating at STARVE_LIMIT.
//  - Fault check on the granted request:
//    - Misaligned: halfword with addr[0]=1; word or fetch with addr[1:0]!=0.
//    - Out of range: not in RAM and not in MMIO.
//  - Memory drive in the grant cycle (combinational):
//    - mem_read_address = mem_write_address = granted addr.
//    - mem_funct3 = 3'b010 for fetch, d_funct3 for data.
//    - mem_write = d_ready & d_we & ~fault.
//    - mem_write_data = d_wdata.
//  - Idle cycles drive address 0, funct3 3'b010, mem_write 0.
//  - Faulting requests are accepted (ready=1) but never write memory.
//  - Response pipeline register {owner(NONE/IF/D), err, is_store} is loaded at every grant and set to NONE when nothing is granted.
//  - Cycle N+1 response:
//    - if_rvalid = (owner==IF); if_rdata = err ? 0 : mem_read_data.
//    - d_rvalid = (owner==D); d_rdata = (err | is_store) ? 0 : mem_read_data.
//    - *_err = err.
//  - Back-to-back grants are fully pipelined: one response per cycle, no bubbles.
//  - No response backpressure: the requester must accept rvalid in the cycle it is asserted.
//  - Requests must hold addr/funct3/wdata stable until ready. A request withdrawn before ready is simply never granted.
//  - Reset (async):
//    - owner=NONE, starve_cnt=0; all *_rvalid, *_err, *_rdata, mem_write = 0.
//    - An access granted in the cycle before reset produces no response.
// TESTING
//  - Reset mid-load:
//    - D load at 0x100 granted, rst asserted next cycle -> no d_rvalid.
//    - After release, all outputs are 0 until a new request.
//  - Data/fetch pipeline:
//    - Word store 0xDEADBEEF to 0x40, then LW 0x40 -> mem_write=1 in cycle 0 only; d_rvalid in cycles 1 and 2.
//    - Load result d_rdata=0xDEADBEEF; store response has d_rdata=0.
//    - LB from 0x43 after storing 0x80 there -> d_rdata=0xFFFFFF80 (mem_funct3=3'b000 at grant).
//  - Contention with STARVE_LIMIT=4:
//    - if_req and d_req held high continuously -> D granted 4 cycles, then IF 1 cycle; pattern repeats.
//    - if_rvalid/d_rvalid each follow their grant by exactly 1 cycle.
//  - Faults:
//    - LW at 0x42 -> d_rvalid=1, d_err=1, d_rdata=0.
//    - SW at 0x00004000 -> d_err=1, mem_write=0.
//    - Fetch at 0x6 -> if_err=1.
//  - MMIO:
//    - SW 0x11223344 to 0xFFFFFFFC -> mem_write=1, no error.
//    - LW from 0xFFFFFFFC -> d_rdata=0x11223344; read of 0xFFFFFFF8 is accepted with no error.

Source files
------------

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: shares one byte-lane memory port between instruction fetch and data accesses
//   clk, rst                   clock, async active-high reset
//   if_req/if_addr             fetch request (held until if_ready)
//   if_ready                   fetch accepted this cycle
//   if_rvalid/if_rdata/if_err  fetch response, one cycle after acceptance
//   d_req/d_we/d_funct3        data request (held until d_ready), store flag, RISC-V funct3
//   d_addr/d_wdata             data address and store data
//   d_ready                    data request accepted this cycle
//   d_rvalid/d_rdata/d_err     data response, one cycle after acceptance
//   mem_*                      memory drive: write strobe, funct3, addresses, write data, read data (1-cycle latency)
module mem_access_arbiter #(
   parameter int STARVE_LIMIT  = 4,
   parameter int RAM_ADDR_BITS = 13
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ready,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   output logic        if_err,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [2:0]  d_funct3,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ready,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        d_err,
   output logic        mem_write,
   output logic [2:0]  mem_funct3,
   output logic [31:0] mem_write_address,
   output logic [31:0] mem_write_data,
   output logic [31:0] mem_read_address,
   input  logic [31:0] mem_read_data
);
   localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;
   owner_t        owner, owner_nx;
   logic          err, err_nx, is_store, is_store_nx;
   logic [CW-1:0] starve_cnt, starve_nx;
   logic          fetch_force, grant, fault, misaligned, in_ram, in_mmio;
   logic [31:0]   addr;
   logic [2:0]    f3;
   // IF is forced through once data has won STARVE_LIMIT times in a row while IF waited
   assign fetch_force = if_req & (starve_cnt == CW'(STARVE_LIMIT));
   assign d_ready     = d_req & ~fetch_force;
   assign if_ready    = if_req & ~d_ready;
   assign grant       = if_ready | d_ready;
   assign addr        = d_ready ? d_addr : (if_ready ? if_addr : 32'd0);
   assign f3          = d_ready ? d_funct3 : 3'b010;
   // fetches use funct3 010, so they get the word alignment check
   assign misaligned  = ((f3[1:0] == 2'b01) & addr[0]) | ((f3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
   assign in_ram      = (addr >> RAM_ADDR_BITS) == 32'd0;
   assign in_mmio     = addr >= 32'hFFFF_FFF4;
   assign fault       = misaligned | ~(in_ram | in_mmio);
   assign mem_read_address  = addr;
   assign mem_write_address = addr;
   assign mem_funct3        = f3;
   assign mem_write         = d_ready & d_we & ~fault;
   assign mem_write_data    = d_wdata;
   always_comb begin
      owner_nx    = d_ready ? OWN_D : (if_ready ? OWN_IF : OWN_NONE);
      err_nx      = grant & fault;
      is_store_nx = d_ready & d_we;
      starve_nx   = (if_ready | ~if_req) ? '0 :
                    (d_ready & (starve_cnt != CW'(STARVE_LIMIT))) ? starve_cnt + 1'b1 : starve_cnt;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner      <= OWN_NONE;
         err        <= 1'b0;
         is_store   <= 1'b0;
         starve_cnt <= '0;
      end else begin
         owner      <= owner_nx;
         err        <= err_nx;
         is_store   <= is_store_nx;
         starve_cnt <= starve_nx;
      end
   end
   // responses are gated by owner so nothing leaks out while idle or after reset
   assign if_rvalid = owner == OWN_IF;
   assign d_rvalid  = owner == OWN_D;
   assign if_err    = if_rvalid & err;
   assign d_err     = d_rvalid & err;
   assign if_rdata  = (if_rvalid & ~err) ? mem_read_data : 32'd0;
   assign d_rdata   = (d_rvalid & ~err & ~is_store) ? mem_read_data : 32'd0;
endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter: randomized and directed scoreboard bench for mem_access_arbiter
module tb_mem_access_arbiter;
   localparam int SL = 4;
   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_ready, if_rvalid, if_err;
   logic [31:0] if_addr, if_rdata;
   logic        d_req, d_we, d_ready, d_rvalid, d_err;
   logic [2:0]  d_funct3, mem_funct3;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic        mem_write;
   logic [31:0] mem_write_address, mem_write_data, mem_read_address, mem_read_data;

   mem_access_arbiter #(.STARVE_LIMIT(SL), .RAM_ADDR_BITS(13)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
      .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .mem_write(mem_write), .mem_funct3(mem_funct3), .mem_write_address(mem_write_address),
      .mem_write_data(mem_write_data), .mem_read_address(mem_read_address), .mem_read_data(mem_read_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0, errors = 0;
   function automatic void chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
      end
   endfunction

   // byte-addressed storage: 8 KiB RAM followed by the three MMIO words
   function automatic int idx(input logic [31:0] a);
      return (a < 32'h2000) ? int'(a) : (a >= 32'hFFFF_FFF4) ? 8192 + int'(a - 32'hFFFF_FFF4) : 0;
   endfunction

   function automatic logic [31:0] ext(input logic [31:0] w, input logic [2:0] f3);
      case (f3)
         3'b000:  return {{24{w[7]}}, w[7:0]};
         3'b001:  return {{16{w[15]}}, w[15:0]};
         3'b100:  return {24'd0, w[7:0]};
         3'b101:  return {16'd0, w[15:0]};
         default: return w;
      endcase
   endfunction

   // memory stub standing in for the byte-lane memory/MMIO block
   logic [7:0] env_mem [0:8207];
   always @(posedge clk) begin
      if (rst) begin
         foreach (env_mem[i]) env_mem[i] <= 8'd0;
      end else if (mem_write) begin
         for (int k = 0; k < (1 << mem_funct3[1:0]); k++)
            env_mem[idx(mem_write_address) + k] <= mem_write_data[8*k +: 8];
      end
      mem_read_data <= ext({env_mem[idx(mem_read_address) + 3], env_mem[idx(mem_read_address) + 2],
                            env_mem[idx(mem_read_address) + 1], env_mem[idx(mem_read_address)]}, mem_funct3);
   end

   // reference model state
   logic [7:0] ref_mem [0:8207];
   int skipped = 0;
   typedef struct {bit is_if; bit err; logic [31:0] rdata; int due;} exp_t;
   exp_t exp_q[$];

   function automatic bit legal(input logic [31:0] a);
      return a < 32'h2000 || a >= 32'hFFFF_FFF4;
   endfunction

   function automatic bit misal(input logic [31:0] a, input logic [2:0] f3);
      return (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00);
   endfunction

   // one clock: called ~1 unit after posedge with inputs set, returns ~1 unit after the next posedge
   task automatic cycle(output bit gi, output bit gd);
      logic [31:0] a, rd;
      logic [2:0]  f3;
      bit          flt, st;
      #2;
      gd  = d_req && !(if_req && skipped >= SL);
      gi  = if_req && !gd;
      chk("if_ready", 32'(if_ready), 32'(gi));
      chk("d_ready", 32'(d_ready), 32'(gd));
      a   = gi ? if_addr : gd ? d_addr : 32'd0;
      f3  = gd ? d_funct3 : 3'b010;
      st  = gd && d_we;
      flt = (gi || gd) && (misal(a, f3) || !legal(a));
      chk("mem_read_address", mem_read_address, a);
      chk("mem_write_address", mem_write_address, a);
      chk("mem_funct3", 32'(mem_funct3), 32'(f3));
      chk("mem_write", 32'(mem_write), 32'(st && !flt));
      if (st && !flt) chk("mem_write_data", mem_write_data, d_wdata);
      if (gi || gd) begin
         rd = (flt || st) ? 32'd0 :
              ext({ref_mem[idx(a) + 3], ref_mem[idx(a) + 2], ref_mem[idx(a) + 1], ref_mem[idx(a)]}, f3);
         if (st && !flt)
            for (int k = 0; k < (1 << f3[1:0]); k++) ref_mem[idx(a) + k] = d_wdata[8*k +: 8];
         exp_q.push_back('{gi, flt, rd, cyc + 1});
      end
      skipped = (gi || !if_req) ? 0 : skipped + (gd ? 1 : 0);
      @(posedge clk);
      #1;
   endtask

   // scoreboard monitor: every cycle either the due response or silence
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) continue;
         if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            chk("if_rvalid", 32'(if_rvalid), 32'(e.is_if));
            chk("d_rvalid", 32'(d_rvalid), 32'(!e.is_if));
            chk(e.is_if ? "if_err" : "d_err", 32'(e.is_if ? if_err : d_err), 32'(e.err));
            chk(e.is_if ? "if_rdata" : "d_rdata", e.is_if ? if_rdata : d_rdata, e.rdata);
         end else begin
            chk("idle_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
         end
      end
   end

   function automatic logic [31:0] rand_addr();
      int r = $urandom_range(0, 9);
      return r < 6 ? 32'($urandom_range(0, 63)) : r < 8 ? 32'hFFFF_FFF4 + 32'($urandom_range(0, 11)) :
             r == 8 ? 32'h2000 + 32'($urandom_range(0, 255)) : 32'($urandom);
   endfunction

   function automatic logic [31:0] rand_fetch();
      logic [31:0] a = rand_addr();
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      return a;
   endfunction

   task automatic new_d();
      int t;
      d_req   = 1'b1;
      d_we    = 1'($urandom_range(0, 1));
      t       = d_we ? $urandom_range(0, 2) : $urandom_range(0, 4);
      d_funct3 = 3'(t < 3 ? t : t + 1);
      d_addr  = rand_addr();
      d_wdata = $urandom;
   endtask

   task automatic dreq(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      bit gi, gd;
      int n = 0;
      d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = a; d_wdata = wd;
      do begin cycle(gi, gd); n++; end while (!gd && n < 16);
      chk("d_grant", 32'(gd), 32'd1);
      d_req = 1'b0;
   endtask

   task automatic ifreq(input logic [31:0] a);
      bit gi, gd;
      int n = 0;
      if_req = 1'b1; if_addr = a;
      do begin cycle(gi, gd); n++; end while (!gi && n < 16);
      chk("if_grant", 32'(gi), 32'd1);
      if_req = 1'b0;
   endtask

   task automatic check_quiet(input string n);
      chk(n, {25'd0, if_ready, d_ready, if_rvalid, d_rvalid, if_err, d_err, mem_write}, 32'd0);
      chk({n, "_rdata"}, if_rdata | d_rdata, 32'd0);
   endtask

   initial begin
      bit gi, gd;
      logic [31:0] mask;
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit gi, gd;
      logic [31:0] mask;
      rst = 1'b1; if_req = 1'b0; if_addr = 32'd0;
      d_req = 1'b0; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'd0; d_wdata = 32'd0;
      foreach (ref_mem[i]) ref_mem[i] = 8'd0;
      repeat (3) @(posedge clk);
      #1 check_quiet("reset_state");
      rst = 1'b0;

      // load granted, then reset before its response can be seen
      dreq(1'b0, 3'b010, 32'h100, 32'd0);
      rst = 1'b1;
      exp_q.delete();
      skipped = 0;
      foreach (ref_mem[i]) ref_mem[i] = 8'd0;
      #1 chk("rst_kills_d_rvalid", 32'(d_rvalid), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) begin cycle(gi, gd); check_quiet("post_reset_quiet"); end

      // data pipeline, sign extension
      dreq(1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF);
      dreq(1'b0, 3'b010, 32'h40, 32'd0);
      dreq(1'b1, 3'b000, 32'h43, 32'h0000_0080);
      dreq(1'b0, 3'b000, 32'h43, 32'd0);
      dreq(1'b0, 3'b100, 32'h43, 32'd0);
      dreq(1'b0, 3'b101, 32'h42, 32'd0);
      ifreq(32'h40);

      // faults
      dreq(1'b0, 3'b010, 32'h42, 32'd0);
      dreq(1'b1, 3'b010, 32'h0000_4000, 32'h1234_5678);
      dreq(1'b0, 3'b001, 32'h41, 32'd0);
      ifreq(32'h6);
      ifreq(32'h0000_2000);

      // MMIO
      dreq(1'b1, 3'b010, 32'hFFFF_FFFC, 32'h1122_3344);
      dreq(1'b0, 3'b010, 32'hFFFF_FFFC, 32'd0);
      dreq(1'b0, 3'b010, 32'hFFFF_FFF8, 32'd0);
      dreq(1'b0, 3'b010, 32'hFFFF_FFF0, 32'd0);

      // sustained contention: four data wins, then one fetch
      if_req = 1'b1; if_addr = rand_fetch(); new_d();
      mask = 32'd0;
      for (int n = 0; n < 10; n++) begin
         cycle(gi, gd);
         mask[n] = gi;
         if (gi) if_addr = rand_fetch();
         if (gd) new_d();
      end
      if_req = 1'b0; d_req = 1'b0;
      chk("starve_pattern", mask, 32'h0000_0210);
      cycle(gi, gd);

      // random traffic with occasional withdrawals
      for (int n = 0; n < 500; n++) begin
         if (!if_req && $urandom_range(0, 1) == 1) begin if_req = 1'b1; if_addr = rand_fetch(); end
         else if (if_req && $urandom_range(0, 15) == 0) if_req = 1'b0;
         if (!d_req && $urandom_range(0, 2) != 0) new_d();
         else if (d_req && $urandom_range(0, 15) == 0) d_req = 1'b0;
         cycle(gi, gd);
         if (gi) if_req = 1'b0;
         if (gd) d_req = 1'b0;
      end
      if_req = 1'b0; d_req = 1'b0;
      repeat (3) cycle(gi, gd);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
